gpio_pad_sequencer: RTL and testbench

GPIO_PAD_SEQUENCER -- requirements
Module: gpio_pad_sequencer

---
 rtl/gpio_pad_sequencer_pkg.sv | 52 +++++
 rtl/gpio_sync2.sv | 28 ++
 rtl/gpio_pad_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_gpio_pad_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_sequencer_pkg.sv
// Shared definitions for the GPIO pad sequencer: config word layout,
// register map, reset configuration and apply-sequence states.
package gpio_pad_sequencer_pkg;

    localparam int CFG_W          = 13;
    localparam int CFG_OUT        = 0;
    localparam int CFG_OEB        = 1;
    localparam int CFG_INP_DIS    = 2;
    localparam int CFG_DM0        = 3;
    localparam int CFG_DM1        = 4;
    localparam int CFG_DM2        = 5;
    localparam int CFG_IB_MODE    = 6;
    localparam int CFG_VTRIP      = 7;
    localparam int CFG_SLOW       = 8;
    localparam int CFG_HOLDOVER   = 9;
    localparam int CFG_ANALOG_EN  = 10;
    localparam int CFG_ANALOG_SEL = 11;
    localparam int CFG_ANALOG_POL = 12;

    typedef logic [CFG_W-1:0] pad_cfg_t;

    // oeb=1, inp_dis=1, dm=001: pad tristated with inputs off after reset
    localparam pad_cfg_t CFG_RESET = 13'h000E;

    localparam logic [7:0] ADDR_CTRL    = 8'hC0;
    localparam logic [7:0] ADDR_GPIN_LO = 8'hC4;
    localparam logic [7:0] ADDR_GPIN_HI = 8'hC8;

    localparam int CTRL_APPLY   = 0;
    localparam int CTRL_BUSY    = 0;
    localparam int CTRL_PENDING = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_UPDATE  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ENABLE  = 3'd4
    } seq_state_e;

    // Byte-strobed merge of bus data into a 13-bit config word.
    function automatic pad_cfg_t merge_cfg(input pad_cfg_t old_cfg,
                                           input logic [CFG_W-1:0] wdata,
                                           input logic [1:0] wstrb);
        pad_cfg_t r_new;
        r_new = old_cfg;
        if (wstrb[0]) r_new[7:0]       = wdata[7:0];
        if (wstrb[1]) r_new[CFG_W-1:8] = wdata[CFG_W-1:8];
        return r_new;
    endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous pad inputs.
module gpio_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments make both stages sample pre-edge values;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gpio_pad_sequencer.sv
// Memory-mapped GPIO pad configuration with shadow/active words and a
// glitch-safe apply sequence that holds outputs disabled while configs change.
module gpio_pad_sequencer
    import gpio_pad_sequencer_pkg::*;
#(
    parameter int NPADS         = 44,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [7:0]       iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NPADS-1:0] gpio_in,
    output logic [NPADS-1:0] gpio_out,
    output logic [NPADS-1:0] gpio_oeb,
    output logic [NPADS-1:0] gpio_inp_dis,
    output logic [NPADS-1:0] gpio_dm2,
    output logic [NPADS-1:0] gpio_dm1,
    output logic [NPADS-1:0] gpio_dm0,
    output logic [NPADS-1:0] gpio_ib_mode_sel,
    output logic [NPADS-1:0] gpio_vtrip_sel,
    output logic [NPADS-1:0] gpio_slow_sel,
    output logic [NPADS-1:0] gpio_holdover,
    output logic [NPADS-1:0] gpio_analog_en,
    output logic [NPADS-1:0] gpio_analog_sel,
    output logic [NPADS-1:0] gpio_analog_pol,
    output logic             busy
);

    logic             r_ready;
    logic [31:0]      r_rdata;
    pad_cfg_t         r_shadow [NPADS];
    pad_cfg_t         r_active [NPADS];
    seq_state_e       r_state;
    logic             r_pending;
    logic [7:0]       r_settle_cnt;

    logic [NPADS-1:0] w_gpio_sync;
    logic [63:0]      w_gpin_all;
    logic             w_req;
    logic             w_wr;
    logic [5:0]       w_idx;
    logic             w_is_pad;
    logic             w_is_ctrl;
    logic             w_apply_req;
    logic             w_busy;
    logic             w_force_oeb;
    logic [31:0]      w_rd_value;
    logic             w_unused;

    gpio_sync2 #(.WIDTH(NPADS)) u_gpio_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (gpio_in),
        .o_q   (w_gpio_sync)
    );

    assign w_gpin_all  = 64'(w_gpio_sync);
    assign w_req       = iomem_valid && !r_ready;
    assign w_wr        = w_req && (|iomem_wstrb);
    assign w_idx       = iomem_addr[7:2];
    assign w_is_pad    = int'(w_idx) < NPADS;
    assign w_is_ctrl   = (w_idx == ADDR_CTRL[7:2]);
    assign w_apply_req = w_wr && w_is_ctrl && iomem_wstrb[0] && iomem_wdata[CTRL_APPLY];
    assign w_busy      = (r_state != ST_IDLE);
    assign w_force_oeb = (r_state == ST_QUIESCE) || (r_state == ST_UPDATE) ||
                         (r_state == ST_SETTLE);
    assign w_unused    = ^{iomem_addr[1:0], iomem_wdata[31:CFG_W]};

    // NOTE: every output gets a default before the case/loop so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_rd_value = '0;
        if (w_is_pad) begin
            for (int p = 0; p < NPADS; p++) begin
                if (p == int'(w_idx)) w_rd_value = 32'(r_shadow[p]);
            end
        end else if (w_is_ctrl) begin
            w_rd_value[CTRL_BUSY]    = w_busy;
            w_rd_value[CTRL_PENDING] = r_pending;
        end else if (w_idx == ADDR_GPIN_LO[7:2]) begin
            w_rd_value = w_gpin_all[31:0];
        end else if (w_idx == ADDR_GPIN_HI[7:2]) begin
            w_rd_value = w_gpin_all[63:32];
        end
    end

    // Ack one cycle after valid is seen; the r_ready term blocks a second ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_req;
            r_rdata <= (w_req && !w_wr) ? w_rd_value : 32'd0;
        end
    end

    // NOTE: the config arrays are reset because they drive pad pins directly;
    // a pure data memory would normally be left unreset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NPADS; p++) begin
                r_shadow[p] <= CFG_RESET;
                r_active[p] <= CFG_RESET;
            end
        end else begin
            for (int p = 0; p < NPADS; p++) begin
                if (w_wr && w_is_pad && (p == int'(w_idx))) begin
                    r_shadow[p] <= merge_cfg(r_shadow[p], iomem_wdata[CFG_W-1:0],
                                             iomem_wstrb[1:0]);
                    if (iomem_wstrb[0]) r_active[p][CFG_OUT] <= iomem_wdata[CFG_OUT];
                end
                // Copy reads the pre-edge shadow, so a same-cycle write waits
                if (r_state == ST_UPDATE) begin
                    r_active[p][CFG_W-1:1] <= r_shadow[p][CFG_W-1:1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_settle_cnt <= '0;
        end else begin
            if (w_apply_req && (r_state != ST_IDLE)) r_pending <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_apply_req || r_pending) begin
                        r_state   <= ST_QUIESCE;
                        r_pending <= 1'b0;
                    end
                end
                ST_QUIESCE: r_state <= ST_UPDATE;
                ST_UPDATE: begin
                    r_state      <= ST_SETTLE;
                    r_settle_cnt <= 8'(SETTLE_CYCLES);
                end
                ST_SETTLE: begin
                    if (r_settle_cnt <= 8'd1) r_state <= ST_ENABLE;
                    else                      r_settle_cnt <= r_settle_cnt - 8'd1;
                end
                ST_ENABLE: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gpio_out         = '0;
        gpio_oeb         = '0;
        gpio_inp_dis     = '0;
        gpio_dm2         = '0;
        gpio_dm1         = '0;
        gpio_dm0         = '0;
        gpio_ib_mode_sel = '0;
        gpio_vtrip_sel   = '0;
        gpio_slow_sel    = '0;
        gpio_holdover    = '0;
        gpio_analog_en   = '0;
        gpio_analog_sel  = '0;
        gpio_analog_pol  = '0;
        for (int p = 0; p < NPADS; p++) begin
            gpio_out[p]         = r_active[p][CFG_OUT];
            gpio_oeb[p]         = r_active[p][CFG_OEB] | w_force_oeb;
            gpio_inp_dis[p]     = r_active[p][CFG_INP_DIS];
            gpio_dm2[p]         = r_active[p][CFG_DM2];
            gpio_dm1[p]         = r_active[p][CFG_DM1];
            gpio_dm0[p]         = r_active[p][CFG_DM0];
            gpio_ib_mode_sel[p] = r_active[p][CFG_IB_MODE];
            gpio_vtrip_sel[p]   = r_active[p][CFG_VTRIP];
            gpio_slow_sel[p]    = r_active[p][CFG_SLOW];
            gpio_holdover[p]    = r_active[p][CFG_HOLDOVER];
            gpio_analog_en[p]   = r_active[p][CFG_ANALOG_EN];
            gpio_analog_sel[p]  = r_active[p][CFG_ANALOG_SEL];
            gpio_analog_pol[p]  = r_active[p][CFG_ANALOG_POL];
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign busy        = w_busy;

endmodule

// File: tb/tb_gpio_pad_sequencer.sv
// Scoreboard bench for gpio_pad_sequencer: bus reads checked by a monitor
// against a register-level model; apply sequences timed by observation.
module tb_gpio_pad_sequencer;

    localparam int NPADS  = 44;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             iomem_valid;
    logic             iomem_ready;
    logic [3:0]       iomem_wstrb;
    logic [7:0]       iomem_addr;
    logic [31:0]      iomem_wdata;
    logic [31:0]      iomem_rdata;
    logic [NPADS-1:0] gpio_in;
    logic [NPADS-1:0] gpio_out, gpio_oeb, gpio_inp_dis, gpio_dm2, gpio_dm1, gpio_dm0;
    logic [NPADS-1:0] gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover;
    logic [NPADS-1:0] gpio_analog_en, gpio_analog_sel, gpio_analog_pol;
    logic             busy;

    always #5 clk = ~clk;

    gpio_pad_sequencer #(.NPADS(NPADS), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb),
        .gpio_inp_dis(gpio_inp_dis), .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1),
        .gpio_dm0(gpio_dm0), .gpio_ib_mode_sel(gpio_ib_mode_sel),
        .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel),
        .gpio_holdover(gpio_holdover), .gpio_analog_en(gpio_analog_en),
        .gpio_analog_sel(gpio_analog_sel), .gpio_analog_pol(gpio_analog_pol),
        .busy(busy)
    );

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t         sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [12:0] m_shadow [NPADS];
    logic [12:0] m_active [NPADS];
    logic [12:0] m_snap   [NPADS];
    int          n_seq = 0;
    int          exp_seq = 0;
    int          ep_len = 0;
    int          ep_oeb_bad = 0;
    int          idle_rdata_bad = 0;
    logic        prev_ready = 1'b0;
    logic        prev_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] bus_merge(input logic [12:0] old, input logic [31:0] wd,
                                              input logic [3:0] st);
        logic [31:0] w;
        w = 32'(old);
        for (int b = 0; b < 4; b++) if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w[12:0];
    endfunction

    // Monitor: pops one scoreboard entry per ack, tracks each apply episode.
    always @(negedge clk) begin
        if (reset) begin
            ep_len = 0; ep_oeb_bad = 0; prev_busy = 1'b0; prev_ready = 1'b0;
        end else begin
            if (iomem_ready) begin
                check("ack_single_cycle", 64'(prev_ready), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.is_rd) check(e.name, 64'(iomem_rdata), 64'(e.exp));
                end
            end else if (iomem_rdata !== 32'd0) begin
                idle_rdata_bad++;
            end
            if (busy) begin
                ep_len++;
                if (ep_len <= 2 + SETTLE && gpio_oeb !== {NPADS{1'b1}}) ep_oeb_bad++;
            end else if (prev_busy) begin
                n_seq++;
                check("busy_cycles", 64'(ep_len), 64'(3 + SETTLE));
                check("oeb_forced_during_seq", 64'(ep_oeb_bad), 64'd0);
                ep_len = 0;
                ep_oeb_bad = 0;
            end
            prev_ready = iomem_ready;
            prev_busy  = busy;
        end
    end

    task automatic bus(input logic [7:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       input bit is_rd, input logic [31:0] exp, input string name);
        sb_t e;
        bit  got;
        e.is_rd = is_rd; e.exp = exp; e.name = name;
        sb_q.push_back(e);
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) begin got = 1'b1; break; end
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        check("ack_seen", 64'(got), 64'd1);
    endtask

    task automatic write_pad(input int p, input logic [31:0] wd, input logic [3:0] strb,
                             input logic [1:0] lowbits);
        bus(8'(4 * p) | 8'(lowbits), strb, wd, 1'b0, 32'd0, "wr_pad");
        m_shadow[p] = bus_merge(m_shadow[p], wd, strb);
        if (strb[0]) m_active[p][0] = wd[0];
    endtask

    task automatic read_pad(input int p);
        bus(8'(4 * p), 4'h0, 32'd0, 1'b1, 32'(m_shadow[p]), "rd_pad");
    endtask

    task automatic apply_start();
        for (int p = 0; p < NPADS; p++) m_snap[p] = m_shadow[p];
        exp_seq++;
        bus(8'hC0, 4'h1, 32'h1, 1'b0, 32'd0, "wr_ctrl");
    endtask

    task automatic check_outputs(input string tag);
        logic [NPADS-1:0] e [13];
        for (int b = 0; b < 13; b++) e[b] = '0;
        for (int p = 0; p < NPADS; p++)
            for (int b = 0; b < 13; b++) e[b][p] = m_active[p][b];
        check({tag, "_out"},     64'(gpio_out),         64'(e[0]));
        check({tag, "_oeb"},     64'(gpio_oeb),         64'(e[1]));
        check({tag, "_inp_dis"}, 64'(gpio_inp_dis),     64'(e[2]));
        check({tag, "_dm"},      64'(gpio_dm0 ^ (gpio_dm1 << 1) ^ (gpio_dm2 << 2)),
                                 64'(e[3] ^ (e[4] << 1) ^ (e[5] << 2)));
        check({tag, "_dm2"},     64'(gpio_dm2),         64'(e[5]));
        check({tag, "_misc"},    64'(gpio_ib_mode_sel ^ gpio_vtrip_sel ^ gpio_slow_sel),
                                 64'(e[6] ^ e[7] ^ e[8]));
        check({tag, "_hold_an"}, 64'(gpio_holdover ^ gpio_analog_en ^ gpio_analog_sel ^ gpio_analog_pol),
                                 64'(e[9] ^ e[10] ^ e[11] ^ e[12]));
        check({tag, "_vtrip"},   64'(gpio_vtrip_sel),   64'(e[7]));
        check({tag, "_apol"},    64'(gpio_analog_pol),  64'(e[12]));
    endtask

    task automatic finish_apply(input string tag);
        for (int i = 0; i < 200 && n_seq < exp_seq; i++) begin @(posedge clk); #1; end
        check("apply_done_in_time", 64'(n_seq >= exp_seq), 64'd1);
        for (int p = 0; p < NPADS; p++) m_active[p][12:1] = m_snap[p][12:1];
        check_outputs(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < NPADS; p++) begin m_shadow[p] = 13'h000E; m_active[p] = 13'h000E; end
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] gin;
        iomem_valid = 1'b0; iomem_wstrb = 4'h0; iomem_addr = 8'h0; iomem_wdata = 32'h0;
        gpio_in = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(iomem_ready), 64'd0);
        check("rst_oeb_all_ones", 64'(gpio_oeb), 64'({NPADS{1'b1}}));
        check("rst_dm0_all_ones", 64'(gpio_dm0), 64'({NPADS{1'b1}}));
        check_outputs("rst");
        bus(8'h14, 4'h0, 32'd0, 1'b1, 32'h0000000E, "rd_pad5_reset");
        bus(8'hC0, 4'h0, 32'd0, 1'b1, 32'h0, "rd_ctrl_reset");

        // Shadow write then apply; then a config that enables pad 3's driver
        write_pad(3, 32'h0002, 4'hF, 2'b00);
        check_outputs("pre_apply");
        apply_start();
        finish_apply("apply1");
        write_pad(3, 32'h0009, 4'hF, 2'b00);
        apply_start();
        finish_apply("apply2");
        check("pad3_oeb_released", 64'(gpio_oeb[3]), 64'd0);

        // Out bit takes effect without apply; drive mode untouched
        write_pad(10, 32'h0001, 4'h1, 2'b00);
        check("pad10_out_immediate", 64'(gpio_out[10]), 64'd1);
        check_outputs("out_direct");

        // Shadow write landing in the UPDATE cycle waits for the next apply
        apply_start();
        write_pad(7, 32'h1FF0, 4'h3, 2'b00);
        finish_apply("update_race");
        check("pad7_dm_old", 64'(gpio_dm2[7]), 64'd0);
        apply_start();
        finish_apply("update_race_next");

        // Two requests while busy merge into one further sequence
        apply_start();
        bus(8'hC0, 4'h1, 32'h1, 1'b0, 32'd0, "wr_ctrl_busy1");
        bus(8'hC0, 4'h1, 32'h1, 1'b0, 32'd0, "wr_ctrl_busy2");
        bus(8'hC0, 4'h0, 32'd0, 1'b1, 32'h3, "rd_ctrl_busy_pending");
        exp_seq++;
        finish_apply("pending");
        repeat (20) @(posedge clk);
        #1;
        check("pending_one_extra_seq", 64'(n_seq), 64'(exp_seq));
        bus(8'hC0, 4'h0, 32'd0, 1'b1, 32'h0, "rd_ctrl_idle");

        // Input synchronizer and unmapped space
        gpio_in = '0;
        gpio_in[40] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus(8'hC8, 4'h0, 32'd0, 1'b1, 32'h00000100, "rd_gpin_hi_bit8");
        gpio_in[40] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus(8'hC8, 4'h0, 32'd0, 1'b1, 32'h0, "rd_gpin_hi_clear");
        bus(8'hFC, 4'h0, 32'd0, 1'b1, 32'h0, "rd_unmapped_fc");
        bus(8'hFC, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'd0, "wr_unmapped_fc");

        // Randomized traffic
        for (int it = 0; it < 120; it++) begin
            int op;
            int p;
            op = $urandom_range(0, 5);
            p  = $urandom_range(0, NPADS - 1);
            case (op)
                0, 1: write_pad(p, $urandom, 4'($urandom_range(1, 15)), 2'($urandom_range(0, 3)));
                2:    read_pad(p);
                3: begin
                    int idx;
                    idx = ($urandom_range(0, 1) == 0) ? 44 + $urandom_range(0, 3)
                                                      : 51 + $urandom_range(0, 12);
                    if ($urandom_range(0, 1) == 0)
                        bus(8'(4 * idx), 4'h0, 32'd0, 1'b1, 32'h0, "rd_unmapped");
                    else
                        bus(8'(4 * idx), 4'hF, $urandom, 1'b0, 32'd0, "wr_unmapped");
                end
                4: begin
                    gpio_in = NPADS'({$urandom, $urandom});
                    gin = 64'(gpio_in);
                    repeat (2) begin @(posedge clk); #1; end
                    bus(8'hC4, 4'h0, 32'd0, 1'b1, gin[31:0], "rd_gpin_lo");
                    bus(8'hC8, 4'h0, 32'd0, 1'b1, gin[63:32], "rd_gpin_hi");
                end
                default: begin
                    apply_start();
                    finish_apply("rand_apply");
                end
            endcase
        end
        for (int p = 0; p < NPADS; p++) read_pad(p);

        // Reset during SETTLE aborts the sequence
        write_pad(20, 32'h0123, 4'h3, 2'b00);
        bus(8'hC0, 4'h1, 32'h1, 1'b0, 32'd0, "wr_ctrl_abort");
        repeat (3) begin @(posedge clk); #1; end
        check("busy_before_abort", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("busy_after_abort", 64'(busy), 64'd0);
        for (int p = 0; p < NPADS; p++) begin m_shadow[p] = 13'h000E; m_active[p] = 13'h000E; end
        check_outputs("abort");
        reset = 1'b0;
        @(posedge clk); #1;
        read_pad(20);
        bus(8'hC0, 4'h0, 32'd0, 1'b1, 32'h0, "rd_ctrl_after_abort");

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        check("rdata_zero_when_idle", 64'(idle_rdata_bad), 64'd0);
        check("sequence_total", 64'(n_seq), 64'(exp_seq));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
